result_vector_collector: RTL and testbench

- Receive end of the tridiagonal matrix-by-vector datapath.
- Accepts per-beat bundles of no_of_units row results from the decoder stage under a valid/ready handshake.
- Discards padding rows and packs the real rows into one full-width result vector for the next cluster iteration.
- Signals completion with done; output packing matches the vector-input packing of the multiplier.

---
 rtl/result_vector_collector.sv | 116 +++++++++++
 tb/tb_result_vector_collector.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_vector_collector.sv
// Result vector collector: receive end of the tridiagonal matrix-by-vector
// datapath. Accepts beats of no_of_units row results, drops the padding rows
// and packs the real rows into one result vector (row 0 in the MSB slot).
//
// Handshake: a beat transfers on a rising clk edge where in_valid && in_ready.
// in_ready is a registered output that is high on every cycle spent in COLLECT
// and low otherwise. in_data is ignored whenever no transfer happens.
module result_vector_collector #(
  parameter int no_of_eqn_per_cluster = 10,
  parameter int element_width         = 32,
  parameter int no_of_units           = 4,
  parameter int NI                    = 8,
  // NI padding rows when N is already a multiple of NI, matching the producer.
  localparam int additional  = NI - (no_of_eqn_per_cluster % NI),
  localparam int total       = no_of_eqn_per_cluster + additional,
  localparam int no_of_beats = total / no_of_units,
  localparam int BCW         = $clog2(no_of_beats + 1)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [no_of_units*element_width-1:0]           in_data,
  output logic [no_of_eqn_per_cluster*element_width-1:0] out_vector,
  output logic [BCW-1:0]                                 beat_count,
  output logic                                           done,
  output logic [1:0]                                     dbg_state
);

  localparam int N = no_of_eqn_per_cluster;
  localparam int W = element_width;
  localparam int U = no_of_units;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(no_of_beats - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           in_ready_q, in_ready_d;
  logic           done_q, done_d;
  logic [N*W-1:0] vec_q, vec_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic           xfer;

  // in_ready_q is only ever high in COLLECT, so this is the accepted-beat strobe.
  assign xfer = in_valid && in_ready_q;

  // Next-state, vector packing and beat counting.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          vec_d   = '0;
          cnt_d   = '0;
        end
      end
      COLLECT: begin
        if (!start) begin
          state_d = IDLE;
        end else if (xfer) begin
          // Row r arrives in beat r/U, lane U-1-(r%U); rows >= N are padding
          // and simply have no destination slot.
          for (int r = 0; r < N; r++) begin
            if (cnt_q == BCW'(r / U)) begin
              vec_d[(N-r)*W-1 -: W] = in_data[(U-1-(r%U))*W +: W];
            end
          end
          cnt_d = cnt_q + BCW'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == COLLECT);
    done_d     = (state_d == DONE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      done_q     <= 1'b0;
      vec_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      done_q     <= done_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign done       = done_q;
  assign out_vector = vec_q;
  assign beat_count = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_result_vector_collector.sv
// Bench for result_vector_collector: default instance (N=10) checked every
// cycle against a row-array model, plus an N=16 instance driven directly.
module tb_result_vector_collector;

  localparam int W    = 32;
  localparam int U    = 4;
  localparam int NA   = 10;
  localparam int NBA  = 4;   // 6 padding rows, 16 total, 4 beats
  localparam int NBN  = 16;
  localparam int NBB  = 6;   // 8 padding rows, 24 total, 6 beats

  localparam logic [NA*W-1:0] EXP100 = {
    32'd100, 32'd101, 32'd102, 32'd103, 32'd104,
    32'd105, 32'd106, 32'd107, 32'd108, 32'd109
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             start_a, valid_a, ready_a, done_a;
  logic [U*W-1:0]   data_a;
  logic [NA*W-1:0]  vec_a;
  logic [2:0]       cnt_a;
  logic [1:0]       st_a;

  logic             start_b, valid_b, ready_b, done_b;
  logic [U*W-1:0]   data_b;
  logic [NBN*W-1:0] vec_b;
  logic [2:0]       cnt_b;
  logic [1:0]       st_b;

  result_vector_collector dut_a (
    .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a),
    .in_ready(ready_a), .in_data(data_a), .out_vector(vec_a),
    .beat_count(cnt_a), .done(done_a), .dbg_state(st_a)
  );

  result_vector_collector #(.no_of_eqn_per_cluster(NBN)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b),
    .in_ready(ready_b), .in_data(data_b), .out_vector(vec_b),
    .beat_count(cnt_b), .done(done_b), .dbg_state(st_b)
  );

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  function automatic void check(input string name, input logic [511:0] act,
                                input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [U*W-1:0] beat(input int base, input int b);
    logic [U*W-1:0] d;
    for (int k = 0; k < U; k++) d[k*W +: W] = 32'(base + b*U + (U-1-k));
    return d;
  endfunction

  function automatic logic [NA*W-1:0] exp_a(input int base);
    logic [NA*W-1:0] e;
    for (int r = 0; r < NA; r++) e[(NA-r)*W-1 -: W] = 32'(base + r);
    return e;
  endfunction

  function automatic logic [NBN*W-1:0] exp_b(input int base);
    logic [NBN*W-1:0] e;
    for (int r = 0; r < NBN; r++) e[(NBN-r)*W-1 -: W] = 32'(base + r);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_a(input logic s, input logic v, input logic [U*W-1:0] d);
    start_a = s; valid_a = v; data_a = d;
    tick();
  endtask

  task automatic drive_b(input logic s, input logic v, input logic [U*W-1:0] d);
    start_b = s; valid_b = v; data_b = d;
    tick();
  endtask

  // ---------------- model of instance A ----------------
  // phase: 0 idle, 1 collecting, 2 vector complete
  int              m_phase = 0;
  int              m_beats = 0;
  logic [W-1:0]    m_rows [NA];
  logic [NA*W-1:0] m_vec;

  // Model update from the inputs seen at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_beats = 0;
      for (int r = 0; r < NA; r++) m_rows[r] = '0;
    end else if (!start_a) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_beats = 0;
      for (int r = 0; r < NA; r++) m_rows[r] = '0;
    end else if (m_phase == 1 && valid_a) begin
      for (int k = 0; k < U; k++) begin
        int row;
        row = m_beats*U + (U-1-k);
        if (row < NA) m_rows[row] = data_a[k*W +: W];
      end
      m_beats++;
      if (m_beats == NBA) m_phase = 2;
    end
  end

  // Compare instance A against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int r = 0; r < NA; r++) m_vec[(NA-r)*W-1 -: W] = m_rows[r];
      check("cyc_in_ready", 512'(ready_a), 512'(m_phase == 1));
      check("cyc_done", 512'(done_a), 512'(m_phase == 2));
      check("cyc_beat_count", 512'(cnt_a), 512'(m_beats));
      check("cyc_out_vector", 512'(vec_a), 512'(m_vec));
      check("cyc_state", 512'(st_a), 512'(m_phase));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    start_a = 1'b0; valid_a = 1'b0; data_a = '0;
    start_b = 1'b0; valid_b = 1'b0; data_b = '0;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_out_vector", 512'(vec_a), 512'(0));
    check("rst_done", 512'(done_a), 512'(0));
    check("rst_in_ready", 512'(ready_a), 512'(0));
    check("rst_beat_count", 512'(cnt_a), 512'(0));
    reset = 1'b0;

    // Back-to-back beats, rows 0..15 carry 100+row.
    drive_a(1, 0, '0);
    for (int b = 0; b < NBA; b++) begin
      if (b == NBA-1) check("b2b_done_early", 512'(done_a), 512'(0));
      drive_a(1, 1, beat(100, b));
    end
    check("b2b_done", 512'(done_a), 512'(1));
    check("b2b_vector", 512'(vec_a), 512'(EXP100));
    check("b2b_count", 512'(cnt_a), 512'(4));

    // Beats offered while done are ignored.
    for (int i = 0; i < 3; i++) drive_a(1, 1, {U{32'hFFFFFFFF}});
    check("post_done_vector", 512'(vec_a), 512'(EXP100));
    check("post_done_ready", 512'(ready_a), 512'(0));
    check("post_done_count", 512'(cnt_a), 512'(4));

    // Same vector with valid gaps 1,0,0,1,1,0,1.
    drive_a(0, 0, '0);
    drive_a(1, 0, '0);
    check("gap_cleared", 512'(vec_a), 512'(0));
    begin
      logic [6:0] pat;
      int b;
      pat = 7'b1001101;
      b = 0;
      for (int i = 6; i >= 0; i--) begin
        if (i == 0) check("gap_done_early", 512'(done_a), 512'(0));
        if (pat[i]) begin
          drive_a(1, 1, beat(100, b));
          b++;
        end else begin
          drive_a(1, 0, {U{32'hDEADBEEF}});
        end
      end
    end
    check("gap_done", 512'(done_a), 512'(1));
    check("gap_vector", 512'(vec_a), 512'(EXP100));
    check("gap_count", 512'(cnt_a), 512'(4));

    // Reset after two beats, then a fresh full run.
    drive_a(0, 0, '0);
    drive_a(1, 0, '0);
    drive_a(1, 1, beat(200, 0));
    drive_a(1, 1, beat(200, 1));
    reset = 1'b1;
    drive_a(1, 0, '0);
    reset = 1'b0;
    check("mid_rst_state", 512'(st_a), 512'(0));
    check("mid_rst_vector", 512'(vec_a), 512'(0));
    check("mid_rst_done", 512'(done_a), 512'(0));
    check("mid_rst_ready", 512'(ready_a), 512'(0));
    drive_a(1, 0, '0);
    for (int b = 0; b < NBA; b++) drive_a(1, 1, beat(100, b));
    check("after_rst_done", 512'(done_a), 512'(1));
    check("after_rst_vector", 512'(vec_a), 512'(EXP100));

    // Drop start after three beats (with a beat offered that cycle).
    drive_a(0, 0, '0);
    drive_a(1, 0, '0);
    for (int b = 0; b < 3; b++) drive_a(1, 1, beat(200, b));
    drive_a(0, 1, beat(200, 3));
    check("drop_state", 512'(st_a), 512'(0));
    check("drop_done", 512'(done_a), 512'(0));
    check("drop_vector_held", 512'(vec_a), 512'(exp_a(200)));
    check("drop_count_held", 512'(cnt_a), 512'(3));
    drive_a(0, 0, '0);
    drive_a(1, 0, '0);
    check("restart_vector", 512'(vec_a), 512'(0));
    check("restart_count", 512'(cnt_a), 512'(0));
    for (int b = 0; b < 3; b++) drive_a(1, 1, beat(300, b));
    check("restart_not_done", 512'(done_a), 512'(0));
    drive_a(1, 1, beat(300, 3));
    check("restart_done", 512'(done_a), 512'(1));
    check("restart_vector_full", 512'(vec_a), 512'(exp_a(300)));
    drive_a(1, 0, '0);

    // N=16 instance: six beats, the last two are all padding.
    drive_b(1, 0, '0);
    for (int b = 0; b < NBB; b++) begin
      if (b == NBB-1) check("n16_done_early", 512'(done_b), 512'(0));
      drive_b(1, 1, beat(100, b));
    end
    check("n16_done", 512'(done_b), 512'(1));
    check("n16_count", 512'(cnt_b), 512'(6));
    check("n16_ready", 512'(ready_b), 512'(0));
    check("n16_vector", 512'(vec_b), 512'(exp_b(100)));
    drive_b(0, 0, '0);
    check("n16_idle_done", 512'(done_b), 512'(0));
    check("n16_idle_vector", 512'(vec_b), 512'(exp_b(100)));

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
